// File: rtl/pipeline_regs_if_id_ex_mem.sv
// IF/ID, ID/EX and EX/MEM pipeline latch banks for the five-stage CPU.
// Each group captures on its own enable and clears to an all-zero bubble on reset.
module pipeline_regs_if_id_ex_mem #(
    parameter int DW = 64,
    parameter int IW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_if_id,
    input  logic          en_id_ex,
    input  logic          en_ex_mem,
    // IF/ID
    input  logic [IW-1:0] if_instr_d,
    output logic [IW-1:0] if_instr_q,
    input  logic [DW-1:0] if_pc_d,
    output logic [DW-1:0] if_pc_q,
    // ID/EX
    input  logic [DW-1:0] id_rd1_d,
    output logic [DW-1:0] id_rd1_q,
    input  logic [DW-1:0] id_rd2_d,
    output logic [DW-1:0] id_rd2_q,
    input  logic [DW-1:0] id_pc_d,
    output logic [DW-1:0] id_pc_q,
    input  logic [DW-1:0] id_imm_d,
    output logic [DW-1:0] id_imm_q,
    input  logic [RW-1:0] id_rn_d,
    output logic [RW-1:0] id_rn_q,
    input  logic [RW-1:0] id_rm_d,
    output logic [RW-1:0] id_rm_q,
    input  logic [RW-1:0] id_rd_d,
    output logic [RW-1:0] id_rd_q,
    input  logic [5:0]    id_ex_ctl_d,
    output logic [5:0]    id_ex_ctl_q,
    input  logic [4:0]    id_m_ctl_d,
    output logic [4:0]    id_m_ctl_q,
    input  logic [1:0]    id_wb_ctl_d,
    output logic [1:0]    id_wb_ctl_q,
    // EX/MEM
    input  logic [DW-1:0] ex_alu_d,
    output logic [DW-1:0] ex_alu_q,
    input  logic [DW-1:0] ex_wdata_d,
    output logic [DW-1:0] ex_wdata_q,
    input  logic [DW-1:0] ex_baddr_d,
    output logic [DW-1:0] ex_baddr_q,
    input  logic [RW-1:0] ex_rd_d,
    output logic [RW-1:0] ex_rd_q,
    input  logic [4:0]    ex_m_ctl_d,
    output logic [4:0]    ex_m_ctl_q,
    input  logic [1:0]    ex_wb_ctl_d,
    output logic [1:0]    ex_wb_ctl_q,
    input  logic [3:0]    ex_aluflags_d,
    output logic [3:0]    ex_aluflags_q,
    input  logic [3:0]    ex_regflags_d,
    output logic [3:0]    ex_regflags_q
);

    logic [IW-1:0] r_if_instr;
    logic [DW-1:0] r_if_pc;

    logic [DW-1:0] r_id_rd1, r_id_rd2, r_id_pc, r_id_imm;
    logic [RW-1:0] r_id_rn, r_id_rm, r_id_rd;
    logic [5:0]    r_id_ex_ctl;
    logic [4:0]    r_id_m_ctl;
    logic [1:0]    r_id_wb_ctl;

    logic [DW-1:0] r_ex_alu, r_ex_wdata, r_ex_baddr;
    logic [RW-1:0] r_ex_rd;
    logic [4:0]    r_ex_m_ctl;
    logic [1:0]    r_ex_wb_ctl;
    logic [3:0]    r_ex_aluflags, r_ex_regflags;

    // NOTE: non-blocking assignments so every group samples its d inputs as they
    // stood before the edge, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (en_if_id) begin
            r_if_instr <= if_instr_d;
            r_if_pc    <= if_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_rd1    <= '0;
            r_id_rd2    <= '0;
            r_id_pc     <= '0;
            r_id_imm    <= '0;
            r_id_rn     <= '0;
            r_id_rm     <= '0;
            r_id_rd     <= '0;
            r_id_ex_ctl <= '0;
            r_id_m_ctl  <= '0;
            r_id_wb_ctl <= '0;
        end else if (en_id_ex) begin
            r_id_rd1    <= id_rd1_d;
            r_id_rd2    <= id_rd2_d;
            r_id_pc     <= id_pc_d;
            r_id_imm    <= id_imm_d;
            r_id_rn     <= id_rn_d;
            r_id_rm     <= id_rm_d;
            r_id_rd     <= id_rd_d;
            r_id_ex_ctl <= id_ex_ctl_d;
            r_id_m_ctl  <= id_m_ctl_d;
            r_id_wb_ctl <= id_wb_ctl_d;
        end
    end

    // All-zero control fields make the reset state a bubble in MEM and WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_alu      <= '0;
            r_ex_wdata    <= '0;
            r_ex_baddr    <= '0;
            r_ex_rd       <= '0;
            r_ex_m_ctl    <= '0;
            r_ex_wb_ctl   <= '0;
            r_ex_aluflags <= '0;
            r_ex_regflags <= '0;
        end else if (en_ex_mem) begin
            r_ex_alu      <= ex_alu_d;
            r_ex_wdata    <= ex_wdata_d;
            r_ex_baddr    <= ex_baddr_d;
            r_ex_rd       <= ex_rd_d;
            r_ex_m_ctl    <= ex_m_ctl_d;
            r_ex_wb_ctl   <= ex_wb_ctl_d;
            r_ex_aluflags <= ex_aluflags_d;
            r_ex_regflags <= ex_regflags_d;
        end
    end

    assign if_instr_q    = r_if_instr;
    assign if_pc_q       = r_if_pc;

    assign id_rd1_q      = r_id_rd1;
    assign id_rd2_q      = r_id_rd2;
    assign id_pc_q       = r_id_pc;
    assign id_imm_q      = r_id_imm;
    assign id_rn_q       = r_id_rn;
    assign id_rm_q       = r_id_rm;
    assign id_rd_q       = r_id_rd;
    assign id_ex_ctl_q   = r_id_ex_ctl;
    assign id_m_ctl_q    = r_id_m_ctl;
    assign id_wb_ctl_q   = r_id_wb_ctl;

    assign ex_alu_q      = r_ex_alu;
    assign ex_wdata_q    = r_ex_wdata;
    assign ex_baddr_q    = r_ex_baddr;
    assign ex_rd_q       = r_ex_rd;
    assign ex_m_ctl_q    = r_ex_m_ctl;
    assign ex_wb_ctl_q   = r_ex_wb_ctl;
    assign ex_aluflags_q = r_ex_aluflags;
    assign ex_regflags_q = r_ex_regflags;

endmodule

// File: tb/tb_pipeline_regs_if_id_ex_mem.sv
// Scoreboard bench for the pipeline latch banks: a driver pushes the expected
// register contents per event, a monitor pops and compares after each edge.
module tb_pipeline_regs_if_id_ex_mem;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ifid_t;

    typedef struct packed {
        logic [63:0] rd1, rd2, pc, imm;
        logic [4:0]  rn, rm, rd;
        logic [5:0]  ex_ctl;
        logic [4:0]  m_ctl;
        logic [1:0]  wb_ctl;
    } idex_t;

    typedef struct packed {
        logic [63:0] alu, wdata, baddr;
        logic [4:0]  rd;
        logic [4:0]  m_ctl;
        logic [1:0]  wb_ctl;
        logic [3:0]  aluflags, regflags;
    } exmem_t;

    typedef struct packed {
        ifid_t  i;
        idex_t  d;
        exmem_t e;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    logic en_if_id, en_id_ex, en_ex_mem;
    ifid_t  d_if;
    idex_t  d_id;
    exmem_t d_ex;

    logic [31:0] if_instr_q;
    logic [63:0] if_pc_q, id_rd1_q, id_rd2_q, id_pc_q, id_imm_q;
    logic [4:0]  id_rn_q, id_rm_q, id_rd_q, id_m_ctl_q, ex_rd_q, ex_m_ctl_q;
    logic [5:0]  id_ex_ctl_q;
    logic [1:0]  id_wb_ctl_q, ex_wb_ctl_q;
    logic [63:0] ex_alu_q, ex_wdata_q, ex_baddr_q;
    logic [3:0]  ex_aluflags_q, ex_regflags_q;

    ifid_t  q_if;
    idex_t  q_id;
    exmem_t q_ex;

    assign q_if = '{instr: if_instr_q, pc: if_pc_q};
    assign q_id = '{rd1: id_rd1_q, rd2: id_rd2_q, pc: id_pc_q, imm: id_imm_q,
                    rn: id_rn_q, rm: id_rm_q, rd: id_rd_q, ex_ctl: id_ex_ctl_q,
                    m_ctl: id_m_ctl_q, wb_ctl: id_wb_ctl_q};
    assign q_ex = '{alu: ex_alu_q, wdata: ex_wdata_q, baddr: ex_baddr_q, rd: ex_rd_q,
                    m_ctl: ex_m_ctl_q, wb_ctl: ex_wb_ctl_q,
                    aluflags: ex_aluflags_q, regflags: ex_regflags_q};

    pipeline_regs_if_id_ex_mem dut (
        .clk(clk), .rst(rst),
        .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
        .if_instr_d(d_if.instr), .if_instr_q(if_instr_q),
        .if_pc_d(d_if.pc), .if_pc_q(if_pc_q),
        .id_rd1_d(d_id.rd1), .id_rd1_q(id_rd1_q),
        .id_rd2_d(d_id.rd2), .id_rd2_q(id_rd2_q),
        .id_pc_d(d_id.pc), .id_pc_q(id_pc_q),
        .id_imm_d(d_id.imm), .id_imm_q(id_imm_q),
        .id_rn_d(d_id.rn), .id_rn_q(id_rn_q),
        .id_rm_d(d_id.rm), .id_rm_q(id_rm_q),
        .id_rd_d(d_id.rd), .id_rd_q(id_rd_q),
        .id_ex_ctl_d(d_id.ex_ctl), .id_ex_ctl_q(id_ex_ctl_q),
        .id_m_ctl_d(d_id.m_ctl), .id_m_ctl_q(id_m_ctl_q),
        .id_wb_ctl_d(d_id.wb_ctl), .id_wb_ctl_q(id_wb_ctl_q),
        .ex_alu_d(d_ex.alu), .ex_alu_q(ex_alu_q),
        .ex_wdata_d(d_ex.wdata), .ex_wdata_q(ex_wdata_q),
        .ex_baddr_d(d_ex.baddr), .ex_baddr_q(ex_baddr_q),
        .ex_rd_d(d_ex.rd), .ex_rd_q(ex_rd_q),
        .ex_m_ctl_d(d_ex.m_ctl), .ex_m_ctl_q(ex_m_ctl_q),
        .ex_wb_ctl_d(d_ex.wb_ctl), .ex_wb_ctl_q(ex_wb_ctl_q),
        .ex_aluflags_d(d_ex.aluflags), .ex_aluflags_q(ex_aluflags_q),
        .ex_regflags_d(d_ex.regflags), .ex_regflags_q(ex_regflags_q)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    snap_t sb[$];
    snap_t model;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic logic [511:0] rand_bits();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic ifid_t rand_if();
        logic [511:0] v = rand_bits();
        return ifid_t'(v[$bits(ifid_t)-1:0]);
    endfunction

    function automatic idex_t rand_id();
        logic [511:0] v = rand_bits();
        return idex_t'(v[$bits(idex_t)-1:0]);
    endfunction

    function automatic exmem_t rand_ex();
        logic [511:0] v = rand_bits();
        return exmem_t'(v[$bits(exmem_t)-1:0]);
    endfunction

    // Reference: each group holds whatever it last accepted; reset empties everything.
    task automatic step(input logic r, input logic [2:0] en,
                        input ifid_t nif, input idex_t nid, input exmem_t nex);
        @(negedge clk);
        rst       = r;
        en_if_id  = en[2];
        en_id_ex  = en[1];
        en_ex_mem = en[0];
        d_if = nif;
        d_id = nid;
        d_ex = nex;
        if (r) model = '0;
        else begin
            if (en[2]) model.i = nif;
            if (en[1]) model.d = nid;
            if (en[0]) model.e = nex;
        end
        sb.push_back(model);
    endtask

    // Reset raised between edges: expectation is all-zero with no clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        model = '0;
        sb.push_back(model);
        rst = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb.size() > 0) begin
                s = sb.pop_front();
                check("if_id_group", q_if, s.i);
                check("id_ex_group", q_id, s.d);
                check("ex_mem_group", q_ex, s.e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        ifid_t  nif;
        idex_t  nid;
        exmem_t nex;
        logic [63:0] pc_seq [5];

        rst = 1'b1;
        {en_if_id, en_id_ex, en_ex_mem} = 3'b000;
        d_if = '0; d_id = '0; d_ex = '0;
        model = '0;

        // Held reset dominates enables with non-zero data.
        repeat (2) step(1'b1, 3'b111, rand_if(), rand_id(), rand_ex());

        // Basic capture.
        nif = rand_if(); nif.instr = 32'h8B020020; nif.pc = 64'h10;
        step(1'b0, 3'b111, nif, rand_id(), rand_ex());
        after_edge();
        check("capture_instr", if_instr_q, 32'h8B020020);
        check("capture_pc", if_pc_q, 64'h10);

        // Async reset mid-cycle, held across edges, then released.
        async_reset();
        #2;
        check("async_reset_pc", if_pc_q, 64'h0);
        repeat (2) step(1'b1, 3'b111, rand_if(), rand_id(), rand_ex());

        // Three-deep PC flow via model-side feedback of each stage's contents.
        pc_seq = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        for (int k = 0; k < 5; k++) begin
            nif = rand_if(); nif.pc = pc_seq[k];
            nid = rand_id(); nid.pc = model.i.pc;
            nex = rand_ex(); nex.baddr = model.d.pc;
            step(1'b0, 3'b111, nif, nid, nex);
            after_edge();
            if (k >= 2) check("flow_baddr", ex_baddr_q, pc_seq[k-2]);
        end

        // Independent stall of ID/EX while neighbours advance.
        nid = rand_id(); nid.rd1 = 64'h5;
        step(1'b0, 3'b111, rand_if(), nid, rand_ex());
        for (int k = 0; k < 3; k++) begin
            nif = rand_if();
            nid = rand_id(); nid.rd1 = 64'h9;
            nex = rand_ex();
            step(1'b0, 3'b101, nif, nid, nex);
            after_edge();
            check("stall_rd1_held", id_rd1_q, 64'h5);
            check("stall_if_moves", if_pc_q, nif.pc);
            check("stall_ex_moves", ex_alu_q, nex.alu);
        end
        step(1'b0, 3'b111, rand_if(), nid, rand_ex());
        after_edge();
        check("stall_release", id_rd1_q, 64'h9);

        // Control/flag field integrity.
        nid = rand_id();
        nid.ex_ctl = 6'b101010; nid.m_ctl = 5'b10001; nid.wb_ctl = 2'b10;
        nid.rn = 5'd1; nid.rm = 5'd2; nid.rd = 5'd31;
        nex = rand_ex(); nex.aluflags = 4'b1001; nex.regflags = 4'b0110;
        step(1'b0, 3'b111, rand_if(), nid, nex);
        after_edge();
        check("field_ex_ctl", id_ex_ctl_q, 6'b101010);
        check("field_m_ctl", id_m_ctl_q, 5'b10001);
        check("field_wb_ctl", id_wb_ctl_q, 2'b10);
        check("field_rn_rm_rd", {id_rn_q, id_rm_q, id_rd_q}, {5'd1, 5'd2, 5'd31});
        check("field_flags", {ex_aluflags_q, ex_regflags_q}, 8'b1001_0110);

        // Width extremes on every DW field.
        for (int k = 0; k < 2; k++) begin
            logic [63:0] w;
            w = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            nif = rand_if(); nif.pc = w;
            nid = rand_id(); nid.rd1 = w; nid.rd2 = w; nid.pc = w; nid.imm = w;
            nex = rand_ex(); nex.alu = w; nex.wdata = w; nex.baddr = w;
            step(1'b0, 3'b111, nif, nid, nex);
            after_edge();
            check("extreme_dw", {if_pc_q, id_rd1_q, id_imm_q, ex_alu_q, ex_baddr_q},
                  {w, w, w, w, w});
        end

        // Random enables, data and occasional mid-cycle resets.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(39, 0) == 0) begin
                async_reset();
                step(1'b1, 3'($urandom), rand_if(), rand_id(), rand_ex());
            end
            step(1'b0, 3'($urandom), rand_if(), rand_id(), rand_ex());
        end

        repeat (2) after_edge();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
